// File: rtl/vga_sync_gen_pkg.sv
// Default 640x480@60 raster timing constants and the line/frame total helper,
// shared by the sync generator, pattern blocks and benches.
package vga_sync_gen_pkg;

  localparam int POS_W     = 10;
  localparam int MAX_TOTAL = 1 << POS_W;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Single-axis raster counter: position register plus registered sync, with
// look-ahead active/at_start flags describing the position loaded this edge.
module vga_axis_counter
  import vga_sync_gen_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK,
  parameter bit POL     = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [POS_W-1:0] pos,
  output logic             sync,
  output logic             active,
  output logic             at_start,
  output logic             wrap
);

  localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

  localparam logic [POS_W:0] LAST       = (POS_W+1)'(TOTAL - 1);
  localparam logic [POS_W:0] VIS_END    = (POS_W+1)'(VISIBLE);
  localparam logic [POS_W:0] SYNC_START = (POS_W+1)'(VISIBLE + FRONT);
  localparam logic [POS_W:0] SYNC_END   = (POS_W+1)'(VISIBLE + FRONT + SYNC);

  logic [POS_W-1:0] pos_reg, pos_next;
  logic             sync_reg, sync_next;
  logic [POS_W:0]   pos_ext;

  assign wrap    = ({1'b0, pos_reg} == LAST);
  assign pos_ext = {1'b0, pos_next};

  // Flags are decoded from the next position so the parent can register them
  // on the same edge as the position itself.
  always_comb begin
    pos_next = pos_reg;
    if (inc) begin
      pos_next = wrap ? '0 : pos_reg + POS_W'(1);
    end
    sync_next = ((pos_ext >= SYNC_START) && (pos_ext < SYNC_END)) ? POL : ~POL;
  end

  assign active   = (pos_ext < VIS_END);
  assign at_start = (pos_next == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_reg  <= '0;
      sync_reg <= ~POL;
    end else begin
      pos_reg  <= pos_next;
      sync_reg <= sync_next;
    end
  end

  assign pos  = pos_reg;
  assign sync = sync_reg;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: registered column/row, syncs and position flags.
// Optional macro VGA_SYNC_FRAME_COUNT_EN enables the completed-frame counter.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pixel_en,
  output logic [9:0]  column,
  output logic [9:0]  row,
  output logic        hsync,
  output logic        vsync,
  output logic        visible,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  logic h_active, h_at_start, h_wrap;
  logic v_active, v_at_start, v_wrap;
  logic v_inc;

  assign v_inc = pixel_en & h_wrap;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(HSYNC_POL)
  ) u_h_axis (
    .clk(clk), .reset_n(reset_n), .inc(pixel_en),
    .pos(column), .sync(hsync), .active(h_active), .at_start(h_at_start), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(VSYNC_POL)
  ) u_v_axis (
    .clk(clk), .reset_n(reset_n), .inc(v_inc),
    .pos(row), .sync(vsync), .active(v_active), .at_start(v_at_start), .wrap(v_wrap)
  );

  logic visible_reg, line_start_reg, frame_start_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      visible_reg     <= 1'b1;
      line_start_reg  <= 1'b1;
      frame_start_reg <= 1'b1;
    end else if (pixel_en) begin
      visible_reg     <= h_active & v_active;
      line_start_reg  <= h_at_start;
      frame_start_reg <= h_at_start & v_at_start;
    end
  end

  assign visible     = visible_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

`ifdef VGA_SYNC_FRAME_COUNT_EN
  logic [15:0] frame_count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_reg <= '0;
    end else if (v_inc && v_wrap) begin
      frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign frame_count = frame_count_reg;
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
  assign frame_count   = 16'd0;
`endif

endmodule
